// File: rtl/channel_merge_rr_pkg.sv
// rtl/channel_merge_rr_pkg.sv - shared widths and pick functions for the M-way channel merge
package channel_merge_pkg;

  localparam int MaxM = 64;

  function automatic int id_width(int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  // First requester after 'last', wrapping modulo m; returns 'last' when nothing requests.
  function automatic logic [5:0] rr_pick(logic [MaxM-1:0] req, logic [5:0] last, int m);
    logic [6:0] idx;
    logic       found;
    logic [5:0] res;
    res   = last;
    found = 1'b0;
    for (int i = 1; i <= MaxM; i++) begin
      idx = 7'(last) + 7'(i);
      if (idx >= 7'(m)) idx = idx - 7'(m);
      if (i <= m && !found && req[idx[5:0]]) begin
        res   = idx[5:0];
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [5:0] fp_pick(logic [MaxM-1:0] req, int m);
    logic [5:0] res;
    res = '0;
    for (int i = MaxM - 1; i >= 0; i--) begin
      if (i < m && req[i]) res = 6'(i);
    end
    return res;
  endfunction

endpackage

// File: rtl/channel_merge_rr_if.sv
// rtl/channel_merge_rr_if.sv - single valid/data/ack channel and an M-wide array of them
interface channel_if #(parameter int W = 8);
  logic         v;
  logic         a;
  logic [W-1:0] d;
  modport master (output v, output d, input a);
  modport slave  (input v, input d, output a);
endinterface

interface channel_array_if #(parameter int N = 8, parameter int M = 4);
  logic [M-1:0]        v;
  logic [M-1:0]        a;
  logic [M-1:0][N-1:0] d;
  modport master (output v, output d, input a);
  modport slave  (input v, input d, output a);
endinterface

// File: rtl/channel_merge_rr_skid2.sv
// rtl/channel_merge_rr_skid2.sv - 2-entry registered buffer; no combinational out.a to in.a path
module channel_skid2 #(
  parameter int W = 8
) (
  input  logic      clk,
  input  logic      reset_n,
  channel_if.slave  in,
  channel_if.master out
);

  logic [W-1:0] mem [2];
  logic         wr;
  logic         rd;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign in.a  = (count != 2'd2);
  assign out.v = (count != 2'd0);
  assign out.d = mem[rd];
  assign push  = in.v & in.a;
  assign pop   = out.v & out.a;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr     <= 1'b0;
      rd     <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr] <= in.d;
        wr      <= ~wr;
      end
      if (pop) rd <= ~rd;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/channel_merge_rr.sv
// rtl/channel_merge_rr.sv - M-way merge with RR/fixed arbitration, grant and burst locking, tagged output
module channel_merge_rr
  import channel_merge_pkg::*;
#(
  parameter int N        = 8,
  parameter int M        = 4,
  parameter int Priority = 0,
  parameter int BurstLen = 1,
  localparam int IdW     = id_width(M)
) (
  input  logic             clk,
  input  logic             reset_n,
  channel_array_if.slave   in,
  channel_if.master        out
);

  localparam int BcW = $clog2(BurstLen + 1);

  logic [IdW-1:0] last;
  logic [IdW-1:0] lock_id;
  logic [IdW-1:0] pick;
  logic [IdW-1:0] cur;
  logic           locked;
  logic           burst_lock;
  logic           lock_hold;
  logic           space;
  logic           accept;
  logic           stall;
  logic [BcW-1:0] burst_ct;
  logic [BcW-1:0] ct_eff;

  channel_if #(.W(N + IdW)) push ();

  always_comb begin
    if (Priority != 0) pick = IdW'(fp_pick(64'(in.v), M));
    else               pick = IdW'(rr_pick(64'(in.v), 6'(last), M));
    lock_hold = locked & (in.v[lock_id] | ~burst_lock);
    cur       = lock_hold ? lock_id : pick;
    // A released lock restarts the burst count for whoever wins this cycle.
    ct_eff    = lock_hold ? burst_ct : '0;
    space     = push.a & reset_n;
    accept    = in.v[cur] & space;
    stall     = in.v[cur] & ~space;
    in.a      = '0;
    in.a[cur] = accept;
  end

  assign push.v = accept;
  assign push.d = {cur, in.d[cur]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last       <= IdW'(M - 1);
      locked     <= 1'b0;
      lock_id    <= '0;
      burst_lock <= 1'b0;
      burst_ct   <= '0;
    end else if (accept) begin
      last <= cur;
      if (BurstLen > 1 && int'(ct_eff) + 1 < BurstLen) begin
        locked     <= 1'b1;
        lock_id    <= cur;
        burst_lock <= 1'b1;
        burst_ct   <= ct_eff + 1'b1;
      end else begin
        locked     <= 1'b0;
        burst_lock <= 1'b0;
        burst_ct   <= '0;
      end
    end else if (stall) begin
      locked     <= 1'b1;
      lock_id    <= cur;
      burst_lock <= 1'b0;
      burst_ct   <= ct_eff;
    end else if (!lock_hold) begin
      locked   <= 1'b0;
      burst_ct <= '0;
    end
  end

  channel_skid2 #(.W(N + IdW)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (push),
    .out     (out)
  );

endmodule
